// File: rtl/alarm_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_trigger_ctrl
// Upstream control stage for alarm_clock. Holds the user-set alarm time,
// compares it against the running time-of-day and sequences ring / snooze.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   defined   : snooze pulse moves RING -> SNOOZE for SNOOZE_SECS seconds.
//   undefined : snooze input ignored, SNOOZE state and snz_cnt not built.
//
// Ports:
//   I_CLK          system clock
//   Rst            asynchronous active-low reset
//   sec_tick       1 Hz one-cycle strobe from the time base
//   cur_hour/min/sec  running time-of-day (binary)
//   set_en         alarm-set mode level; inc_hour / inc_min are step pulses
//   alarm_on       arm switch level
//   stop, snooze   one-cycle user pulses
//   alarm_hour/min stored alarm time (registered)
//   count_light    ring pattern phase (registered)
//   count_light1   ring status 0 idle / 1 ringing / 2 snoozing (registered)
//   ringing        high while in RING (registered)
// -----------------------------------------------------------------------------
module alarm_trigger_ctrl #(
    parameter int RING_SECS   = 30,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       I_CLK,
    input  logic       Rst,
    input  logic       sec_tick,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       set_en,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       alarm_on,
    input  logic       stop,
    input  logic       snooze,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic [1:0] count_light,
    output logic [1:0] count_light1,
    output logic       ringing
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

    // Elaboration-time range check on the configuration parameters.
    generate
        if (RING_SECS < 2 || RING_SECS > 255 || SNOOZE_SECS < 2 || SNOOZE_SECS > 1023) begin : g_bad_params
            $error("alarm_trigger_ctrl: RING_SECS or SNOOZE_SECS out of range");
        end
    endgenerate

    state_t     state_r;
    logic [7:0] ring_cnt_r;
    logic       match_s;
    logic       abort_s;
    logic       snooze_s;

`ifdef ALARM_SNOOZE_EN
    localparam logic [9:0] SNZ_LAST = 10'(SNOOZE_SECS - 1);
    logic [9:0] snz_cnt_r;
    assign snooze_s = snooze;
`else
    // Snooze is not built; the input is kept on the port list but sunk here.
    logic unused_snooze_s;
    assign unused_snooze_s = snooze;
    assign snooze_s        = 1'b0;
`endif

    // Alarm match and the common "silence now" condition.
    always_comb begin
        match_s = sec_tick && alarm_on && !set_en && (cur_sec == 6'd0) &&
                  (cur_hour == alarm_hour) && (cur_min == alarm_min);
        abort_s = stop || !alarm_on || set_en;
    end

    // Alarm time registers: independent wrapping hour and minute steppers.
    always_ff @(posedge I_CLK or negedge Rst) begin
        if (!Rst) begin
            alarm_hour <= 5'd7;
            alarm_min  <= 6'd0;
        end else if (set_en) begin
            if (inc_hour) begin
                alarm_hour <= (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
            end
            if (inc_min) begin
                alarm_min <= (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
            end
        end
    end

    // Ring/snooze FSM with registered status outputs and duration counters.
    always_ff @(posedge I_CLK or negedge Rst) begin
        if (!Rst) begin
            state_r      <= ST_IDLE;
            ring_cnt_r   <= 8'd0;
            count_light  <= 2'd0;
            count_light1 <= 2'd0;
            ringing      <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_r    <= 10'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A stop in the match cycle suppresses the trigger.
                    if (match_s && !stop) begin
                        state_r      <= ST_RING;
                        ring_cnt_r   <= 8'd0;
                        count_light  <= 2'd0;
                        count_light1 <= 2'd1;
                        ringing      <= 1'b1;
                    end else begin
                        count_light  <= 2'd0;
                        count_light1 <= 2'd0;
                        ringing      <= 1'b0;
                    end
                end
                ST_RING: begin
                    if (abort_s) begin
                        state_r      <= ST_IDLE;
                        count_light  <= 2'd0;
                        count_light1 <= 2'd0;
                        ringing      <= 1'b0;
                    end else if (snooze_s) begin
                        state_r      <= ST_SNOOZE;
                        count_light  <= 2'd0;
                        count_light1 <= 2'd2;
                        ringing      <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                        snz_cnt_r    <= 10'd0;
`endif
                    end else if (sec_tick) begin
                        if (ring_cnt_r == RING_LAST) begin
                            state_r      <= ST_IDLE;
                            count_light  <= 2'd0;
                            count_light1 <= 2'd0;
                            ringing      <= 1'b0;
                        end else begin
                            count_light <= count_light + 2'd1;
                            if (ring_cnt_r != 8'hFF) begin
                                ring_cnt_r <= ring_cnt_r + 8'd1;
                            end
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    count_light <= 2'd0;
                    if (abort_s) begin
                        state_r      <= ST_IDLE;
                        count_light1 <= 2'd0;
                        ringing      <= 1'b0;
                    end else if (sec_tick) begin
                        if (snz_cnt_r == SNZ_LAST) begin
                            state_r      <= ST_RING;
                            ring_cnt_r   <= 8'd0;
                            count_light1 <= 2'd1;
                            ringing      <= 1'b1;
                        end else if (snz_cnt_r != 10'h3FF) begin
                            snz_cnt_r <= snz_cnt_r + 10'd1;
                        end
                    end
                end
`endif
                default: begin
                    state_r      <= ST_IDLE;
                    count_light  <= 2'd0;
                    count_light1 <= 2'd0;
                    ringing      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_trigger_ctrl.sv
module tb_alarm_trigger_ctrl;

    logic       I_CLK = 1'b0;
    logic       Rst;
    logic       sec_tick, set_en, inc_hour, inc_min, alarm_on, stop, snooze;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [1:0] count_light, count_light1;
    logic       ringing;

    int total = 0;
    int bad   = 0;

    alarm_trigger_ctrl #(.RING_SECS(30), .SNOOZE_SECS(5)) dut (
        .I_CLK(I_CLK), .Rst(Rst), .sec_tick(sec_tick),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .set_en(set_en), .inc_hour(inc_hour), .inc_min(inc_min),
        .alarm_on(alarm_on), .stop(stop), .snooze(snooze),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .count_light(count_light), .count_light1(count_light1), .ringing(ringing)
    );

    always #5 I_CLK = ~I_CLK;

    // One row = one clock cycle at time 07:<min>:<sec>, alarm stored as 07:01.
    typedef struct packed {
        logic       tick;
        logic [5:0] min;
        logic [5:0] sec;
        logic       set;
        logic       on;
        logic       stp;
        logic       snz;
        logic [1:0] e_cl;
        logic [1:0] e_cl1;
        logic       e_ring;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic tick, input logic [5:0] min, input logic [5:0] sec,
                                input logic set, input logic on, input logic stp, input logic snz,
                                input logic [1:0] e_cl, input logic [1:0] e_cl1, input logic e_ring);
        vec_t v;
        v.tick = tick; v.min = min; v.sec = sec; v.set = set; v.on = on;
        v.stp = stp; v.snz = snz; v.e_cl = e_cl; v.e_cl1 = e_cl1; v.e_ring = e_ring;
        return v;
    endfunction

    task automatic cyc();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] eh, input logic [5:0] em,
                         input logic [1:0] ecl, input logic [1:0] ecl1, input logic er);
        total++;
        if ({alarm_hour, alarm_min, count_light, count_light1, ringing} !== {eh, em, ecl, ecl1, er}) begin
            bad++;
            $display("FAIL %s: got h=%0d m=%0d cl=%0d cl1=%0d ring=%0d, want h=%0d m=%0d cl=%0d cl1=%0d ring=%0d",
                     name, alarm_hour, alarm_min, count_light, count_light1, ringing,
                     eh, em, ecl, ecl1, er);
        end
    endtask

    // n second ticks at a non-matching second, each followed by a quiet cycle.
    task automatic tick_n(input int n);
        cur_sec = 6'd5;
        for (int k = 0; k < n; k++) begin
            sec_tick = 1'b1; cyc();
            sec_tick = 1'b0; cyc();
        end
    endtask

    // Drive the matching 07:01:00 tick.
    task automatic fire();
        cur_hour = 5'd7; cur_min = 6'd1; cur_sec = 6'd0;
        alarm_on = 1'b1; set_en = 1'b0;
        sec_tick = 1'b1; cyc();
        sec_tick = 1'b0; cur_sec = 6'd5;
    endtask

    task automatic pulse_snooze(); snooze = 1'b1; cyc(); snooze = 1'b0; endtask
    task automatic pulse_stop();   stop   = 1'b1; cyc(); stop   = 1'b0; endtask

    initial begin
        //        tick min    sec    set   on    stp   snz   cl    cl1   ring
        vecs[0]  = mk(1'b0, 6'd1, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // no tick
        vecs[1]  = mk(1'b1, 6'd1, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // disarmed
        vecs[2]  = mk(1'b1, 6'd1, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0); // stop wins
        vecs[3]  = mk(1'b1, 6'd1, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // set mode
        vecs[4]  = mk(1'b1, 6'd1, 6'd1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // sec != 0
        vecs[5]  = mk(1'b1, 6'd2, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // min mismatch
        vecs[6]  = mk(1'b1, 6'd1, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1); // trigger
        vecs[7]  = mk(1'b0, 6'd1, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1); // hold
        vecs[8]  = mk(1'b1, 6'd1, 6'd1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
        vecs[9]  = mk(1'b1, 6'd1, 6'd2,  1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 1'b1);
        vecs[10] = mk(1'b1, 6'd1, 6'd3,  1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd1, 1'b1);
        vecs[11] = mk(1'b1, 6'd1, 6'd4,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1); // wrap mod 4
        vecs[12] = mk(1'b0, 6'd1, 6'd4,  1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0); // stop+snooze
        vecs[13] = mk(1'b1, 6'd1, 6'd5,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // same minute
        vecs[14] = mk(1'b1, 6'd1, 6'd59, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        vecs[15] = mk(1'b1, 6'd1, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1); // next day
        vecs[16] = mk(1'b0, 6'd1, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // disarm
        vecs[17] = mk(1'b1, 6'd1, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
        vecs[18] = mk(1'b0, 6'd1, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0); // set mode
        vecs[19] = mk(1'b1, 6'd1, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
        vecs[20] = mk(1'b1, 6'd1, 6'd1,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0); // stop > tick

        Rst = 1'b0; sec_tick = 1'b0; set_en = 1'b0; inc_hour = 1'b0; inc_min = 1'b0;
        alarm_on = 1'b0; stop = 1'b0; snooze = 1'b0;
        cur_hour = 5'd7; cur_min = 6'd1; cur_sec = 6'd5;
        repeat (2) cyc();
        check("reset_vals", 5'd7, 6'd0, 2'd0, 2'd0, 1'b0);
        Rst = 1'b1;
        cyc();
        check("idle_after_release", 5'd7, 6'd0, 2'd0, 2'd0, 1'b0);

        // Alarm time setting.
        set_en = 1'b1;
        inc_hour = 1'b1; repeat (17) cyc(); inc_hour = 1'b0;
        check("hour_wrap_17", 5'd0, 6'd0, 2'd0, 2'd0, 1'b0);
        inc_hour = 1'b1; repeat (7) cyc(); inc_hour = 1'b0;
        check("hour_back_7", 5'd7, 6'd0, 2'd0, 2'd0, 1'b0);
        inc_min = 1'b1; repeat (59) cyc(); inc_min = 1'b0;
        check("min_59", 5'd7, 6'd59, 2'd0, 2'd0, 1'b0);
        inc_min = 1'b1; cyc(); inc_min = 1'b0;
        check("min_wrap_60", 5'd7, 6'd0, 2'd0, 2'd0, 1'b0);
        inc_hour = 1'b1; inc_min = 1'b1; cyc(); inc_hour = 1'b0; inc_min = 1'b0;
        check("both_incs", 5'd8, 6'd1, 2'd0, 2'd0, 1'b0);
        inc_hour = 1'b1; repeat (23) cyc(); inc_hour = 1'b0;
        check("alarm_0701", 5'd7, 6'd1, 2'd0, 2'd0, 1'b0);
        set_en = 1'b0;
        inc_min = 1'b1; cyc(); inc_min = 1'b0;
        check("inc_ignored_no_set", 5'd7, 6'd1, 2'd0, 2'd0, 1'b0);

        // Table-driven trigger / ring / priority vectors.
        for (int i = 0; i < 21; i++) begin
            sec_tick = vecs[i].tick; cur_hour = 5'd7; cur_min = vecs[i].min;
            cur_sec = vecs[i].sec; set_en = vecs[i].set; alarm_on = vecs[i].on;
            stop = vecs[i].stp; snooze = vecs[i].snz;
            cyc();
            check($sformatf("vec%0d", i), 5'd7, 6'd1, vecs[i].e_cl, vecs[i].e_cl1, vecs[i].e_ring);
        end
        sec_tick = 1'b0; stop = 1'b0; snooze = 1'b0; set_en = 1'b0; alarm_on = 1'b1;
        cyc();

        // Auto-stop after RING_SECS ticks.
        fire();
        check("auto_enter", 5'd7, 6'd1, 2'd0, 2'd1, 1'b1);
        tick_n(29);
        check("auto_29", 5'd7, 6'd1, 2'd1, 2'd1, 1'b1);
        tick_n(1);
        check("auto_30", 5'd7, 6'd1, 2'd0, 2'd0, 1'b0);

        // Snooze.
        fire();
        tick_n(2);
        check("snz_pre", 5'd7, 6'd1, 2'd2, 2'd1, 1'b1);
        pulse_snooze();
`ifdef ALARM_SNOOZE_EN
        check("snz_enter", 5'd7, 6'd1, 2'd0, 2'd2, 1'b0);
        pulse_snooze();
        check("snz_ignored", 5'd7, 6'd1, 2'd0, 2'd2, 1'b0);
        tick_n(4);
        check("snz_4", 5'd7, 6'd1, 2'd0, 2'd2, 1'b0);
        tick_n(1);
        check("snz_5_rering", 5'd7, 6'd1, 2'd0, 2'd1, 1'b1);
        tick_n(1);
        check("rering_tick", 5'd7, 6'd1, 2'd1, 2'd1, 1'b1);
        pulse_snooze();
        pulse_stop();
        check("snz_stop", 5'd7, 6'd1, 2'd0, 2'd0, 1'b0);
`else
        check("snz_no_effect", 5'd7, 6'd1, 2'd2, 2'd1, 1'b1);
        pulse_stop();
        check("snz_stop", 5'd7, 6'd1, 2'd0, 2'd0, 1'b0);
`endif

        // Asynchronous reset mid-RING.
        fire();
        tick_n(1);
        check("pre_reset_ring", 5'd7, 6'd1, 2'd1, 2'd1, 1'b1);
        Rst = 1'b0;
        #2;
        check("async_reset", 5'd7, 6'd0, 2'd0, 2'd0, 1'b0);
        #1 Rst = 1'b1;
        cyc();
        check("idle_after_reset", 5'd7, 6'd0, 2'd0, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_trigger_ctrl.md
# alarm_trigger_ctrl

Upstream control stage for `alarm_clock`. Holds the user-set alarm time, compares it against the running time-of-day, and sequences ring and snooze. It drives the `count_light`/`count_light1` pattern that `alarm_clock` turns into its output. Time-of-day and a 1 Hz strobe come from the time-base counter.

## Interface
Parameters:
- `RING_SECS`, 30: ring duration in seconds before auto-stop (2..255).
- `SNOOZE_SECS`, 300: snooze duration in seconds (2..1023).

Ports:
- `I_CLK` in 1: system clock.
- `Rst` in 1: reset, asynchronous, active-low.
- `sec_tick` in 1: one-cycle pulse, once per second.
- `cur_hour` in 5: current hour, binary 0..23.
- `cur_min` in 6: current minute, binary 0..59.
- `cur_sec` in 6: current second, binary 0..59.
- `set_en` in 1: alarm-set mode (level).
- `inc_hour` in 1: one-cycle pulse, increments the alarm hour while `set_en` is high.
- `inc_min` in 1: one-cycle pulse, increments the alarm minute while `set_en` is high.
- `alarm_on` in 1: arm switch (level).
- `stop` in 1: one-cycle pulse, silences the alarm.
- `snooze` in 1: one-cycle pulse, requests snooze.
- `alarm_hour` out 5: stored alarm hour.
- `alarm_min` out 6: stored alarm minute.
- `count_light` out 2: ring pattern phase to `alarm_clock`.
- `count_light1` out 2: ring status to `alarm_clock`. 0 = idle, 1 = ringing, 2 = snoozing. Value 3 is never driven.
- `ringing` out 1: high in the RING state.

## Operation
- Reset values: `alarm_hour` = 7, `alarm_min` = 0, `count_light` = 0, `count_light1` = 0, `ringing` = 0, state = IDLE, all counters = 0.
- Alarm set: applies only while `set_en` = 1.
  - `inc_hour` wraps 23 -> 0. `inc_min` wraps 59 -> 0.
  - No carry from minute into hour.
  - If both pulses arrive in the same cycle, both take effect.
- FSM states: IDLE, RING, SNOOZE.
- IDLE -> RING when all of the following hold in one cycle: `sec_tick`, `alarm_on`, `!set_en`, `cur_sec` == 0, `cur_hour` == `alarm_hour`, `cur_min` == `alarm_min`. Entering RING clears `ring_cnt` and `count_light`.
- RING behaviour:
  - On each `sec_tick`, `count_light` increments mod 4 and `ring_cnt` increments.
  - Exits, in priority order:
    1. `stop` -> IDLE.
    2. `alarm_on` = 0 or `set_en` = 1 -> IDLE.
    3. `snooze` -> SNOOZE (clears `snz_cnt`).
    4. `sec_tick` with `ring_cnt` == `RING_SECS`-1 -> IDLE.
- SNOOZE behaviour:
  - `count_light` holds at 0.
  - `snz_cnt` increments on each `sec_tick`.
  - Exits: `stop`, `alarm_on` = 0 or `set_en` = 1 -> IDLE. `sec_tick` with `snz_cnt` == `SNOOZE_SECS`-1 -> RING (clears `ring_cnt`).
  - `snooze` pulses are ignored in this state.
- In IDLE, `count_light` = 0.
- Retrigger: the match requires `cur_sec` == 0, so after a stop the alarm cannot fire again in the same minute.
- Counter widths: `ring_cnt` 8 bits, `snz_cnt` 10 bits. Counters saturate and never wrap inside a state.

## Timing
- All outputs are registered.
- The state, `ringing` and `count_light1` update on the clock edge that samples the triggering event, so they are visible 1 cycle after the event.
- `count_light` advances on the same edge as the `sec_tick` it counts.
- An alarm-set increment is visible on `alarm_hour`/`alarm_min` 1 cycle after the pulse.
- Asserting `Rst` in any state forces the reset values immediately, without waiting for a clock edge. Release is synchronous to the next `I_CLK` edge.
- Simultaneous events resolve by the priority lists in Operation. A `stop` arriving in the same cycle as the IDLE -> RING match keeps the FSM in IDLE.

## Configuration
- `ALARM_SNOOZE_EN` defined:
  - Snooze is supported as described above.
- `ALARM_SNOOZE_EN` undefined:
  - The `snooze` input is ignored.
  - The SNOOZE state and `snz_cnt` are not synthesized.
  - `count_light1` never equals 2.
  - `SNOOZE_SECS` is unused.
  - The port list is unchanged.

## Test plan
- Reset checks:
  - Assert `Rst` = 0 mid-RING -> all outputs return to their reset values asynchronously (`alarm_hour` = 7, `count_light1` = 0).
  - Release `Rst` -> the FSM starts in IDLE.
- Alarm set and trigger:
  - With `set_en` = 1, pulse `inc_hour` 17 times from reset -> `alarm_hour` = 0 (7 + 17 wraps past 23).
  - Pulse `inc_min` 60 times -> `alarm_min` = 0.
  - Set alarm to 07:01, `alarm_on` = 1, `set_en` = 0. Drive time 07:01:00 with `sec_tick` -> `ringing` = 1 and `count_light1` = 1 on the next cycle.
  - 4 further `sec_tick`s -> `count_light` sequence 1, 2, 3, 0.
- Auto-stop: `RING_SECS` = 30, no inputs -> `ringing` falls on the 30th `sec_tick` after entry and `count_light1` = 0.
- Snooze (built with `ALARM_SNOOZE_EN`, `SNOOZE_SECS` = 5):
  - Pulse `snooze` while ringing -> `count_light1` = 2.
  - After 5 `sec_tick`s -> `count_light1` = 1 and `count_light` = 0.
  - Without the macro, the same `snooze` pulse -> no change.
- Priority:
  - `stop` and `snooze` in the same cycle while ringing -> IDLE.
  - Repeat the 07:01:00 `sec_tick` within the same minute after stopping -> the alarm does not retrigger.
  - `alarm_on` = 0 during the match cycle -> no ring.
